// File: rtl/instr_prefetch.sv
// Instruction prefetch queue feeding RI.
// Fetches sequential words into a small FIFO and presents a registered head.
module instr_prefetch #(
   parameter int word_width = 16,
   parameter int addr_width = 16,
   parameter int depth = 4,
   parameter logic [addr_width-1:0] reset_vector = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    flush,
   input  logic [addr_width-1:0]   flush_addr,
   output logic                    mem_req,
   output logic [addr_width-1:0]   mem_addr,
   input  logic                    mem_ack,
   input  logic [word_width-1:0]   mem_rdata,
   output logic                    ri_valid,
   output logic [word_width-1:0]   ri_out,
   output logic [addr_width-1:0]   ri_pc,
   input  logic                    ri_pop,
   output logic [$clog2(depth):0]  level
);

   localparam int pw = $clog2(depth);
   localparam int lw = pw + 1;
   localparam logic [lw-1:0] lvl_full = lw'(depth);
   localparam logic [lw-1:0] lvl_last = lw'(depth - 1);

   typedef enum logic [1:0] {
      S_RESET,
      S_RUN,
      S_FULL
   } state_t;

   state_t state;
   state_t state_next;

   logic [word_width-1:0] ram_data [depth];
   logic [addr_width-1:0] ram_pc [depth];

   logic [pw-1:0]         wr_ptr;
   logic [pw-1:0]         rd_ptr;
   logic [pw-1:0]         rd_ptr_next;
   logic [addr_width-1:0] fetch_pc;
   logic [lw-1:0]         level_next;
   logic                  push;
   logic                  pop;
   logic                  bypass;
   logic [word_width-1:0] hd_data;
   logic [addr_width-1:0] hd_pc;

   assign mem_addr = fetch_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_RESET;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      mem_req = (state == S_RUN) && en && !flush
                && (level != lvl_full);
      push = mem_req && mem_ack;
      pop  = ri_pop && ri_valid && !flush;
      case (state)
         S_RESET: state_next = S_RUN;
         S_RUN: begin
            if (!flush && push && !pop && level == lvl_last)
               state_next = S_FULL;
         end
         S_FULL: begin
            if (flush || pop)
               state_next = S_RUN;
         end
         default: state_next = S_RESET;
      endcase
   end

   always_comb begin
      level_next = level;
      if (push && !pop)
         level_next = level + lw'(1);
      else if (!push && pop)
         level_next = level - lw'(1);
   end

   // Head forwarding: the entry becoming head may be written this very edge.
   always_comb begin
      rd_ptr_next = pop ? rd_ptr + pw'(1) : rd_ptr;
      bypass      = push && (wr_ptr == rd_ptr_next);
      hd_data     = bypass ? mem_rdata : ram_data[rd_ptr_next];
      hd_pc       = bypass ? fetch_pc : ram_pc[rd_ptr_next];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ram_data[wr_ptr] <= mem_rdata;
         ram_pc[wr_ptr]   <= fetch_pc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         fetch_pc <= reset_vector;
         ri_valid <= 1'b0;
         ri_out   <= '0;
         ri_pc    <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         fetch_pc <= flush_addr;
         ri_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + pw'(1);
            fetch_pc <= fetch_pc + addr_width'(1);
         end
         rd_ptr   <= rd_ptr_next;
         level    <= level_next;
         ri_valid <= (level_next != '0);
         if (level_next != '0) begin
            ri_out <= hd_data;
            ri_pc  <= hd_pc;
         end
      end
   end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: vector table plus corner sequences.
// Memory returns addr ^ 'hA5A5 so every word identifies its address.
module tb_instr_prefetch;

   logic        clk;
   logic        rst;
   logic        en;
   logic        flush;
   logic [15:0] flush_addr;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        ri_valid;
   logic [15:0] ri_out;
   logic [15:0] ri_pc;
   logic        ri_pop;
   logic [2:0]  level;

   int pass_cnt = 0;
   int total_cnt = 0;

   instr_prefetch #(
      .word_width(16),
      .addr_width(16),
      .depth(4),
      .reset_vector(16'h0010)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .flush(flush),
      .flush_addr(flush_addr),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .ri_valid(ri_valid),
      .ri_out(ri_out),
      .ri_pc(ri_pc),
      .ri_pop(ri_pop),
      .level(level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] dat(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   assign mem_rdata = dat(mem_addr);

   typedef struct {
      logic        en;
      logic        flush;
      logic [15:0] faddr;
      logic        ack;
      logic        pop;
      logic        req;
      logic [15:0] addr;
      logic        vld;
      logic [15:0] pc;
      logic [15:0] out;
      logic [2:0]  lvl;
   } vec_t;

   function automatic vec_t mk(
      input logic e, input logic f, input logic [15:0] fa,
      input logic a, input logic p, input logic rq,
      input logic [15:0] ad, input logic v,
      input logic [15:0] pc, input logic [15:0] o,
      input logic [2:0] l);
      vec_t r;
      r.en = e; r.flush = f; r.faddr = fa; r.ack = a; r.pop = p;
      r.req = rq; r.addr = ad; r.vld = v; r.pc = pc; r.out = o;
      r.lvl = l;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   vec_t v[$];
   int   lvl_m;
   logic [15:0] exp_pc;
   logic p;
   logic psh;

   initial begin
      rst = 1'b0; en = 1'b0; flush = 1'b0; flush_addr = '0;
      mem_ack = 1'b0; ri_pop = 1'b0;

      // en, flush, faddr, ack, pop | req, addr, vld, pc, out, lvl
      v.push_back(mk(1,0,0,1,0, 0,16'h0010,0,16'h0000,16'h0000,0));
      v.push_back(mk(1,0,0,1,0, 1,16'h0010,0,16'h0000,16'h0000,0));
      v.push_back(mk(1,0,0,1,0, 1,16'h0011,1,16'h0010,dat(16'h0010),1));
      v.push_back(mk(1,0,0,1,0, 1,16'h0012,1,16'h0010,dat(16'h0010),2));
      v.push_back(mk(1,0,0,1,0, 1,16'h0013,1,16'h0010,dat(16'h0010),3));
      v.push_back(mk(1,0,0,1,0, 0,16'h0014,1,16'h0010,dat(16'h0010),4));
      v.push_back(mk(1,0,0,1,1, 0,16'h0014,1,16'h0010,dat(16'h0010),4));
      v.push_back(mk(1,0,0,0,0, 1,16'h0014,1,16'h0011,dat(16'h0011),3));
      v.push_back(mk(1,0,0,0,0, 1,16'h0014,1,16'h0011,dat(16'h0011),3));
      v.push_back(mk(1,0,0,1,0, 1,16'h0014,1,16'h0011,dat(16'h0011),3));
      v.push_back(mk(1,0,0,1,1, 0,16'h0015,1,16'h0011,dat(16'h0011),4));
      v.push_back(mk(1,0,0,1,1, 1,16'h0015,1,16'h0012,dat(16'h0012),3));
      v.push_back(mk(1,0,0,1,1, 1,16'h0016,1,16'h0013,dat(16'h0013),3));
      v.push_back(mk(1,1,16'h0200,1,1, 0,16'h0017,1,16'h0014,dat(16'h0014),3));
      v.push_back(mk(1,0,0,0,0, 1,16'h0200,0,16'h0014,dat(16'h0014),0));
      v.push_back(mk(1,0,0,0,0, 1,16'h0200,0,16'h0014,dat(16'h0014),0));
      v.push_back(mk(1,0,0,0,0, 1,16'h0200,0,16'h0014,dat(16'h0014),0));
      v.push_back(mk(1,0,0,1,0, 1,16'h0200,0,16'h0014,dat(16'h0014),0));
      v.push_back(mk(1,0,0,0,0, 1,16'h0201,1,16'h0200,dat(16'h0200),1));
      v.push_back(mk(0,0,0,1,0, 0,16'h0201,1,16'h0200,dat(16'h0200),1));
      v.push_back(mk(0,0,0,0,1, 0,16'h0201,1,16'h0200,dat(16'h0200),1));
      v.push_back(mk(0,0,0,0,1, 0,16'h0201,0,16'h0200,dat(16'h0200),0));
      v.push_back(mk(1,0,0,1,1, 1,16'h0201,0,16'h0200,dat(16'h0200),0));
      v.push_back(mk(1,0,0,0,0, 1,16'h0202,1,16'h0201,dat(16'h0201),1));

      #1;
      chk("reset_state", {mem_req, ri_valid, ri_out, ri_pc, level},
          {1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0});

      repeat (2) @(negedge clk);
      rst = 1'b1;

      foreach (v[i]) begin
         en = v[i].en; flush = v[i].flush; flush_addr = v[i].faddr;
         mem_ack = v[i].ack; ri_pop = v[i].pop;
         #1;
         chk($sformatf("vec%0d", i),
             {mem_req, mem_addr, ri_valid, ri_pc, ri_out, level},
             {v[i].req, v[i].addr, v[i].vld, v[i].pc, v[i].out, v[i].lvl});
         @(negedge clk);
      end

      // Address wrap through 'hFFFF.
      en = 1'b1; flush = 1'b1; flush_addr = 16'hFFFE;
      mem_ack = 1'b0; ri_pop = 1'b0;
      @(negedge clk);
      flush = 1'b0; mem_ack = 1'b1;
      repeat (3) @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("wrap_pc0", {ri_pc, ri_out, level, mem_addr},
          {16'hFFFE, dat(16'hFFFE), 3'd3, 16'h0001});
      ri_pop = 1'b1;
      @(negedge clk);
      ri_pop = 1'b0;
      #1;
      chk("wrap_pc1", {ri_pc, ri_out}, {16'hFFFF, dat(16'hFFFF)});
      ri_pop = 1'b1;
      @(negedge clk);
      ri_pop = 1'b0;
      #1;
      chk("wrap_pc2", {ri_pc, ri_out, level, ri_valid, mem_req},
          {16'h0000, dat(16'h0000), 3'd1, 1'b1, 1'b1});

      // Asynchronous reset mid-request, checked before the next edge.
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst", {mem_req, ri_valid, level, ri_pc, ri_out},
          {1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000});
      @(negedge clk);
      rst = 1'b1;
      en = 1'b1; mem_ack = 1'b1; ri_pop = 1'b0;
      #1;
      chk("post_rst", {mem_req, mem_addr}, {1'b0, 16'h0010});

      // Fill to two, then push and pop together.
      repeat (3) @(negedge clk);
      #1;
      chk("fill_two", {level, ri_pc}, {3'd2, 16'h0010});
      ri_pop = 1'b1;
      @(negedge clk);
      ri_pop = 1'b0;
      #1;
      chk("pushpop_lvl", {level, ri_pc, ri_out},
          {3'd2, 16'h0011, dat(16'h0011)});

      exp_pc = 16'h0011;
      lvl_m = 2;
      for (int k = 0; k < 20; k++) begin
         p = 1'($urandom_range(0, 1));
         ri_pop = p;
         #1;
         chk($sformatf("rnd_lvl%0d", k), {ri_valid, level},
             {1'b1, 3'(lvl_m)});
         if (p)
            chk($sformatf("rnd_pc%0d", k), {ri_pc, ri_out},
                {exp_pc, dat(exp_pc)});
         psh = (lvl_m != 4);
         if (p) exp_pc = exp_pc + 16'd1;
         lvl_m = lvl_m + int'(psh) - int'(p);
         @(negedge clk);
      end
      ri_pop = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
